// File: rtl/jive_uart_pkg.sv
// Shared types and constants for the JiVe UART host (FSM encoding, bus widths, byte enables).
package jive_uart_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned BUS_W  = 32;
  localparam int unsigned BENA_W = 4;

  localparam logic [BENA_W-1:0] UART_BENA = 4'b0001;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WR_REQ = 2'd1,
    RD_REQ = 2'd2,
    GAP    = 2'd3
  } state_t;

endpackage

// File: rtl/jive_byte_fifo.sv
// Synchronous FIFO with extra-bit pointers; head is the oldest entry, valid while not empty.
module jive_byte_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is accepted only when a pop frees the slot in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/jive_uart_host.sv
// Bus initiator for the JiVe UART slave port: TX FIFO drain, bounded RX polling, round-robin arbitration.
// Optional write timeout enabled by defining JIVE_UART_HOST_TIMEOUT_EN.
module jive_uart_host
  import jive_uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned POLL_CYCLES = 16,
  parameter int unsigned IDLE_GAP    = 2,
  parameter int unsigned TIMEOUT     = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_valid,
  input  logic [BYTE_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              rx_valid,
  output logic [BYTE_W-1:0] rx_data,
  input  logic              rx_ready,
  input  logic              rx_poll_en,
  output logic              bus_csel,
  output logic              bus_rden,
  output logic              bus_wren,
  output logic [BENA_W-1:0] bus_bena,
  output logic [BUS_W-1:0]  bus_wdata,
  input  logic [BUS_W-1:0]  bus_rdata,
  input  logic              bus_dtack,
  output logic              busy,
  output logic              wr_timeout
);

  localparam int unsigned POLL_W = $clog2(POLL_CYCLES + 1);
  localparam int unsigned GAP_W  = $clog2(IDLE_GAP + 1);

  state_t            state;
  state_t            next_state;
  logic [POLL_W-1:0] poll_cnt;
  logic [POLL_W-1:0] poll_cnt_d;
  logic [GAP_W-1:0]  gap_cnt;
  logic [GAP_W-1:0]  gap_cnt_d;
  logic              wr_first;
  logic              wr_first_d;
  logic              arbitrate;
  logic              capture;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [BYTE_W-1:0] fifo_head;
  logic              wr_cand;
  logic              rd_cand;
  logic              unused_bits;

  assign tx_ready  = !fifo_full;
  assign fifo_push = tx_valid && tx_ready;
  assign wr_cand   = !fifo_empty;
  assign rd_cand   = rx_poll_en && !rx_valid;
  assign busy      = (state != IDLE) || !fifo_empty;

  jive_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (BYTE_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (tx_data),
    .pop   (fifo_pop),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef JIVE_UART_HOST_TIMEOUT_EN
  logic [15:0] wr_cnt;
  logic [15:0] wr_cnt_d;
  logic        timeout_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt     <= '0;
      wr_timeout <= 1'b0;
    end else begin
      wr_cnt <= wr_cnt_d;
      if (timeout_hit) wr_timeout <= 1'b1;
    end
  end

  assign unused_bits = ^bus_rdata[BUS_W-1:BYTE_W];
`else
  assign wr_timeout  = 1'b0;
  assign unused_bits = ^{bus_rdata[BUS_W-1:BYTE_W], 32'(TIMEOUT)};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next state; the final GAP cycle arbitrates directly so the bus idles exactly IDLE_GAP cycles.
  always_comb begin
    next_state = state;
    fifo_pop   = 1'b0;
    capture    = 1'b0;
    arbitrate  = 1'b0;
    poll_cnt_d = '0;
    gap_cnt_d  = '0;
    wr_first_d = wr_first;
`ifdef JIVE_UART_HOST_TIMEOUT_EN
    wr_cnt_d    = '0;
    timeout_hit = 1'b0;
`endif
    case (state)
      IDLE: arbitrate = 1'b1;
      WR_REQ: begin
        if (bus_dtack) begin
          fifo_pop   = 1'b1;
          next_state = GAP;
        end
`ifdef JIVE_UART_HOST_TIMEOUT_EN
        else if (wr_cnt == 16'(TIMEOUT - 1)) begin
          fifo_pop    = 1'b1;
          timeout_hit = 1'b1;
          next_state  = GAP;
        end else begin
          wr_cnt_d = wr_cnt + 16'd1;
        end
`endif
      end
      RD_REQ: begin
        if (bus_dtack) begin
          capture    = 1'b1;
          next_state = GAP;
        end else if (poll_cnt == POLL_W'(POLL_CYCLES - 1)) begin
          next_state = GAP;
        end else begin
          poll_cnt_d = poll_cnt + POLL_W'(1);
        end
      end
      GAP: begin
        if (gap_cnt == GAP_W'(IDLE_GAP - 1)) arbitrate = 1'b1;
        else                                 gap_cnt_d = gap_cnt + GAP_W'(1);
      end
      default: next_state = IDLE;
    endcase

    if (arbitrate) begin
      next_state = IDLE;
      if (wr_cand && (wr_first || !rd_cand)) begin
        next_state = WR_REQ;
        wr_first_d = 1'b0;
      end else if (rd_cand) begin
        next_state = RD_REQ;
        wr_first_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      poll_cnt <= '0;
      gap_cnt  <= '0;
      wr_first <= 1'b1;
    end else begin
      poll_cnt <= poll_cnt_d;
      gap_cnt  <= gap_cnt_d;
      wr_first <= wr_first_d;
    end
  end

  // Bus outputs registered from the next state so they track the FSM without a lag cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_csel  <= 1'b0;
      bus_rden  <= 1'b0;
      bus_wren  <= 1'b0;
      bus_bena  <= '0;
      bus_wdata <= '0;
    end else begin
      bus_csel  <= (next_state == WR_REQ) || (next_state == RD_REQ);
      bus_wren  <= (next_state == WR_REQ);
      bus_rden  <= (next_state == RD_REQ);
      bus_bena  <= ((next_state == WR_REQ) || (next_state == RD_REQ)) ? UART_BENA : '0;
      bus_wdata <= (next_state == WR_REQ) ? {{(BUS_W-BYTE_W){1'b0}}, fifo_head} : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_valid <= 1'b0;
      rx_data  <= '0;
    end else if (capture) begin
      rx_valid <= 1'b1;
      rx_data  <= bus_rdata[BYTE_W-1:0];
    end else if (rx_valid && rx_ready) begin
      rx_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_jive_uart_host.sv
// Directed bench for jive_uart_host: write vector table plus hand sequences for FIFO, polling, arbitration, reset.
module tb_jive_uart_host;

  logic        clk;
  logic        rst;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        rx_poll_en;
  logic        bus_csel;
  logic        bus_rden;
  logic        bus_wren;
  logic [3:0]  bus_bena;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_dtack;
  logic        busy;
  logic        wr_timeout;

  jive_uart_host #(
    .FIFO_DEPTH  (4),
    .POLL_CYCLES (16),
    .IDLE_GAP    (2),
    .TIMEOUT     (100)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .rx_poll_en (rx_poll_en),
    .bus_csel   (bus_csel),
    .bus_rden   (bus_rden),
    .bus_wren   (bus_wren),
    .bus_bena   (bus_bena),
    .bus_wdata  (bus_wdata),
    .bus_rdata  (bus_rdata),
    .bus_dtack  (bus_dtack),
    .busy       (busy),
    .wr_timeout (wr_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Bus slave model controls
  bit          wr_ack_en;
  bit          rd_ack_en;
  int          wr_delay;
  int          rd_delay;
  logic [31:0] rd_word;

  typedef struct {
    bit         wr;
    logic [7:0] data;
    int         len;
    int         gap;
  } req_t;

  req_t        log_q[$];
  req_t        cur;
  bit          in_req;
  bit          seen_req;
  int          idle_run;
  int          unstable;
  int          wcnt;
  int          rcnt;
  logic [31:0] first_wdata;
  logic [3:0]  first_bena;

  // Slave model and request monitor, both on the falling edge away from DUT updates.
  always @(negedge clk) begin
    wcnt = bus_wren ? wcnt + 1 : 0;
    rcnt = bus_rden ? rcnt + 1 : 0;
    bus_dtack = (wr_ack_en && bus_wren && wcnt >= wr_delay + 1) ||
                (rd_ack_en && bus_rden && rcnt >= rd_delay + 1);
    bus_rdata = rd_word;
    if (bus_csel) begin
      if (!in_req) begin
        cur.wr   = bus_wren;
        cur.data = bus_wdata[7:0];
        cur.len  = 0;
        cur.gap  = seen_req ? idle_run : -1;
        first_wdata = bus_wdata;
        first_bena  = bus_bena;
      end else if (bus_wdata !== first_wdata || bus_bena !== first_bena) begin
        unstable++;
      end
      cur.len++;
      in_req   = 1'b1;
      idle_run = 0;
    end else begin
      if (in_req) begin
        log_q.push_back(cur);
        seen_req = 1'b1;
      end
      in_req = 1'b0;
      idle_run++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    log_q.delete();
    seen_req = 1'b0;
    unstable = 0;
  endtask

  function automatic req_t log_at(input int k);
    req_t r;
    r.wr = 1'b0; r.data = 8'h00; r.len = 0; r.gap = -1;
    if (k < log_q.size()) r = log_q[k];
    return r;
  endfunction

  task automatic push(input logic [7:0] d);
    int t = 0;
    tx_valid = 1'b1;
    tx_data  = d;
    while (!tx_ready && t < 300) begin step(); t++; end
    check("push_ready", 32'(tx_ready), 32'd1);
    step();
    tx_valid = 1'b0;
  endtask

  task automatic wait_log(input string name, input int n, input int budget);
    int t = 0;
    while (log_q.size() < n && t < budget) begin step(); t++; end
    check(name, 32'(log_q.size() >= n), 32'd1);
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    while (busy && t < 200) begin step(); t++; end
    check(name, 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  typedef struct {
    logic [7:0]  data;
    int          delay;
    logic [31:0] exp_wdata;
    int          exp_len;
  } wr_vec_t;

  wr_vec_t vecs[4];
  logic [8:0] alt_exp[5];

  initial begin
    vecs[0] = '{data: 8'h41, delay: 3, exp_wdata: 32'h0000_0041, exp_len: 4};
    vecs[1] = '{data: 8'h00, delay: 0, exp_wdata: 32'h0000_0000, exp_len: 1};
    vecs[2] = '{data: 8'hFF, delay: 1, exp_wdata: 32'h0000_00FF, exp_len: 2};
    vecs[3] = '{data: 8'h80, delay: 5, exp_wdata: 32'h0000_0080, exp_len: 6};
    alt_exp[0] = 9'h120; alt_exp[1] = 9'h000; alt_exp[2] = 9'h121;
    alt_exp[3] = 9'h000; alt_exp[4] = 9'h122;

    rst = 1'b1; tx_valid = 1'b0; tx_data = 8'h00; rx_ready = 1'b0; rx_poll_en = 1'b0;
    bus_dtack = 1'b0; bus_rdata = 32'h0;
    wr_ack_en = 1'b1; rd_ack_en = 1'b0; wr_delay = 0; rd_delay = 0; rd_word = 32'h0;
    wcnt = 0; rcnt = 0; in_req = 1'b0; seen_req = 1'b0; idle_run = 0; unstable = 0;
    step();
    step();

    check("rst_csel", 32'(bus_csel), 32'd0);
    check("rst_rden", 32'(bus_rden), 32'd0);
    check("rst_wren", 32'(bus_wren), 32'd0);
    check("rst_bena", 32'(bus_bena), 32'd0);
    check("rst_wdata", bus_wdata, 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_tx_ready", 32'(tx_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wr_timeout", 32'(wr_timeout), 32'd0);
    rst = 1'b0;
    step();

    // Single writes with varied data and ack delay
    for (int i = 0; i < 4; i++) begin
      clear_log();
      wr_delay = vecs[i].delay;
      push(vecs[i].data);
      wait_log("vec_done", 1, 50);
      check("vec_is_write", 32'(log_at(0).wr), 32'd1);
      check("vec_wdata", 32'(log_at(0).data), vecs[i].exp_wdata);
      check("vec_len", 32'(log_at(0).len), 32'(vecs[i].exp_len));
      check("vec_stable", 32'(unstable), 32'd0);
      wait_idle("vec_idle");
      check("vec_tx_ready", 32'(tx_ready), 32'd1);
      check("vec_wr_timeout", 32'(wr_timeout), 32'd0);
    end

    // Push-to-wren latency and the enforced gap between writes
    clear_log();
    wr_delay = 3;
    tx_valid = 1'b1;
    tx_data  = 8'h41;
    step();
    tx_valid = 1'b0;
    check("lat_wren_1", 32'(bus_wren), 32'd0);
    step();
    check("lat_wren_2", 32'(bus_wren), 32'd1);
    check("lat_wdata", bus_wdata, 32'h0000_0041);
    check("lat_bena", 32'(bus_bena), 32'h1);
    push(8'h42);
    wait_log("gap_done", 2, 100);
    check("gap_len0", 32'(log_at(0).len), 32'd4);
    check("gap_idle", 32'(log_at(1).gap), 32'd2);
    check("gap_data1", 32'(log_at(1).data), 32'h42);
    wait_idle("gap_idle_end");

    // Five back-to-back bytes against a stalled bus
    clear_log();
    wr_ack_en = 1'b0;
    push(8'h10);
    push(8'h11);
    push(8'h12);
    push(8'h13);
    check("full_tx_ready", 32'(tx_ready), 32'd0);
    wr_ack_en = 1'b1;
    wr_delay  = 0;
    push(8'h14);
    wait_log("b2b_done", 5, 100);
    for (int i = 0; i < 5; i++) check("b2b_order", 32'(log_at(i).data), 32'(8'h10 + i));
    check("b2b_stable", 32'(unstable), 32'd0);
    wait_idle("b2b_idle");

    // Reads never acknowledged: bounded request, gap, retry
    clear_log();
    rd_ack_en  = 1'b0;
    rx_poll_en = 1'b1;
    wait_log("poll_done", 2, 100);
    rx_poll_en = 1'b0;
    check("poll_is_read", 32'(log_at(0).wr), 32'd0);
    check("poll_len", 32'(log_at(0).len), 32'd16);
    check("poll_retry_gap", 32'(log_at(1).gap), 32'd2);
    check("poll_rx_valid", 32'(rx_valid), 32'd0);
    wait_idle("poll_idle");

    // Read acknowledged with consumer stalled
    begin
      int t = 0;
      clear_log();
      rd_ack_en  = 1'b1;
      rd_delay   = 2;
      rd_word    = 32'hFFFF_FF5A;
      rx_ready   = 1'b0;
      rx_poll_en = 1'b1;
      while (!rx_valid && t < 50) begin step(); t++; end
      check("rd_rx_valid", 32'(rx_valid), 32'd1);
      check("rd_rx_data", 32'(rx_data), 32'h5A);
      repeat (30) step();
      check("rd_single_req", 32'(log_q.size()), 32'd1);
      check("rd_len", 32'(log_at(0).len), 32'd3);
      check("rd_held", 32'(rx_valid), 32'd1);
      check("rd_no_rden", 32'(bus_rden), 32'd0);
      rx_ready   = 1'b1;
      rx_poll_en = 1'b0;
      step();
      check("rd_cleared", 32'(rx_valid), 32'd0);
      rx_ready = 1'b0;
      wait_idle("rd_idle");
    end

    // Round-robin alternation, write first after reset
    do_reset();
    clear_log();
    wr_ack_en = 1'b1; wr_delay = 1;
    rd_ack_en = 1'b1; rd_delay = 1; rd_word = 32'h0000_00A5;
    rx_ready  = 1'b1;
    push(8'h20);
    rx_poll_en = 1'b1;
    push(8'h21);
    push(8'h22);
    wait_log("alt_done", 5, 200);
    rx_poll_en = 1'b0;
    for (int i = 0; i < 5; i++)
      check("alt_order", {23'h0, log_at(i).wr, log_at(i).data}, {23'h0, alt_exp[i]});
    wait_idle("alt_idle");
    check("alt_rx_data", 32'(rx_data), 32'hA5);
    rx_ready = 1'b0;

    // Reset in the middle of a write
    begin
      int t = 0;
      wr_ack_en = 1'b0;
      push(8'h33);
      while (!bus_wren && t < 20) begin step(); t++; end
      check("rst_mid_wren_up", 32'(bus_wren), 32'd1);
      #1;
      rst = 1'b1;
      #1;
      check("rst_mid_wren", 32'(bus_wren), 32'd0);
      check("rst_mid_csel", 32'(bus_csel), 32'd0);
      check("rst_mid_wdata", bus_wdata, 32'd0);
      check("rst_mid_bena", 32'(bus_bena), 32'd0);
      check("rst_mid_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      wr_ack_en = 1'b1;
      wr_delay  = 0;
      repeat (6) step();
      check("rst_mid_no_wr", 32'(bus_wren), 32'd0);
      check("rst_mid_ready", 32'(tx_ready), 32'd1);
    end

`ifdef JIVE_UART_HOST_TIMEOUT_EN
    // Write timeout drops the head byte and latches the sticky flag
    clear_log();
    wr_ack_en = 1'b0;
    push(8'h55);
    push(8'h56);
    wait_log("to_done", 1, 300);
    check("to_len", 32'(log_at(0).len), 32'd100);
    check("to_flag", 32'(wr_timeout), 32'd1);
    wr_ack_en = 1'b1;
    wr_delay  = 0;
    wait_log("to_next", 2, 50);
    check("to_next_data", 32'(log_at(1).data), 32'h56);
    wait_idle("to_idle");
    check("to_sticky", 32'(wr_timeout), 32'd1);
    do_reset();
    check("to_rst_clear", 32'(wr_timeout), 32'd0);
`else
    check("no_timeout_flag", 32'(wr_timeout), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
